// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: per-frame bullet pool. Each frame it moves live slots up one slot per cycle,
// retires slots that leave the playfield, then spawns into the lowest free slot if the cooldown allows.
module bullet_pool_ctrl #(
  parameter int N_BULLET = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int SPEED    = 4,
  parameter int Y_MIN    = 0,
  parameter int COOLDOWN = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cal_frame,
  input  logic                      i_shoot,
  input  logic [X_W-1:0]            i_player_x,
  input  logic [Y_W-1:0]            i_player_y,
  output logic [N_BULLET-1:0]       o_bullet_valid,
  output logic [N_BULLET*X_W-1:0]   o_bullet_x,
  output logic [N_BULLET*Y_W-1:0]   o_bullet_y,
  output logic                      o_busy,
  output logic                      o_fired,
  output logic                      o_pool_full,
  output logic                      o_done
);
  localparam int IW = $clog2(N_BULLET);
  localparam int CW = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
  // Retire threshold is one bit wider so Y_MIN+SPEED cannot overflow.
  localparam logic [Y_W:0] THR = (Y_W + 1)'(Y_MIN + SPEED);
  typedef enum logic [1:0] {IDLE, MOVE, SPAWN, DONE} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cd;
  logic shoot_lat;
  logic [X_W-1:0] bx [N_BULLET];
  logic [Y_W-1:0] by [N_BULLET];
  logic free_any;
  logic [IW-1:0] free_idx;
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = N_BULLET - 1; i >= 0; i--)
      if (!o_bullet_valid[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
  end
  for (genvar k = 0; k < N_BULLET; k++) begin : g_out
    assign o_bullet_x[k*X_W +: X_W] = bx[k];
    assign o_bullet_y[k*Y_W +: Y_W] = by[k];
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state          <= IDLE;
      idx            <= '0;
      cd             <= '0;
      shoot_lat      <= 1'b0;
      o_bullet_valid <= '0;
      o_busy         <= 1'b0;
      o_fired        <= 1'b0;
      o_pool_full    <= 1'b0;
      o_done         <= 1'b0;
      for (int i = 0; i < N_BULLET; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
      end
    end else begin
      o_fired     <= 1'b0;
      o_pool_full <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        IDLE: if (i_cal_frame) begin
          state  <= MOVE;
          idx    <= '0;
          o_busy <= 1'b1;
        end
        MOVE: begin
          // The debounced shoot level only settles one cycle after the tick.
          if (idx == '0) shoot_lat <= i_shoot;
          if (o_bullet_valid[idx]) begin
            if ({1'b0, by[idx]} < THR) o_bullet_valid[idx] <= 1'b0;
            else by[idx] <= by[idx] - Y_W'(SPEED);
          end
          idx <= idx + IW'(1);
          if (idx == IW'(N_BULLET - 1)) state <= SPAWN;
        end
        SPAWN: begin
          if (shoot_lat && cd == '0) begin
            if (free_any) begin
              o_bullet_valid[free_idx] <= 1'b1;
              bx[free_idx]             <= i_player_x;
              by[free_idx]             <= i_player_y;
              cd                       <= CW'(COOLDOWN);
              o_fired                  <= 1'b1;
            end else o_pool_full <= 1'b1;
          end else if (cd != '0) cd <= cd - CW'(1);
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// tb_bullet_pool_ctrl: scenario tasks plus randomized frames checked against a frame-level pool model.
module tb_bullet_pool_ctrl;
  localparam int N = 4, XW = 10, YW = 10, SPEED = 4, YMIN = 0, CD = 2;
  logic clk = 0, rst = 1, cal = 0, shoot = 0;
  logic [XW-1:0] px = 0;
  logic [YW-1:0] py = 0;
  logic [N-1:0] valid;
  logic [N*XW-1:0] bx;
  logic [N*YW-1:0] by;
  logic busy, fired, full, done;
  int total = 0, bad = 0;
  bit mv[N];
  int mx[N], my[N], mcd;
  bit got_fired, got_full;
  bit [6:0] fmask;
  always #5 clk = ~clk;
  bullet_pool_ctrl #(.N_BULLET(N), .X_W(XW), .Y_W(YW), .SPEED(SPEED), .Y_MIN(YMIN), .COOLDOWN(CD)) dut (
    .i_clk(clk), .i_rst(rst), .i_cal_frame(cal), .i_shoot(shoot),
    .i_player_x(px), .i_player_y(py),
    .o_bullet_valid(valid), .o_bullet_x(bx), .o_bullet_y(by),
    .o_busy(busy), .o_fired(fired), .o_pool_full(full), .o_done(done));
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0; mx[k] = 0; my[k] = 0;
    end
    mcd = 0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; cal = 0; shoot = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask
  task automatic run_frame(input bit s0, input bit s1, input bit s2, input bit extra,
                           input logic [XW-1:0] x, input logic [YW-1:0] y);
    bit ef = 0, epf = 0;
    int dones = 0, slot = -1;
    for (int k = 0; k < N; k++)
      if (mv[k]) begin
        if (my[k] < YMIN + SPEED) mv[k] = 0;
        else my[k] -= SPEED;
      end
    if (s1 && mcd == 0) begin
      for (int k = N - 1; k >= 0; k--) if (!mv[k]) slot = k;
      if (slot >= 0) begin
        mv[slot] = 1; mx[slot] = x; my[slot] = y; mcd = CD; ef = 1;
      end else epf = 1;
    end else if (mcd > 0) mcd--;
    @(posedge clk); #1;
    cal = 1; shoot = s0; px = x; py = y;
    for (int c = 1; c <= N + 3; c++) begin
      @(posedge clk); #1;
      cal = extra && c == 3;
      shoot = c == 1 ? s1 : s2;
      @(negedge clk);
      total++;
      if (busy !== (c <= N + 2)) begin
        bad++; $display("FAIL busy cycle=%0d got=%b exp=%b", c, busy, c <= N + 2);
      end
      if (done === 1'b1) dones++;
      if (c == N + 2) begin
        got_fired = fired; got_full = full;
        total++;
        if (fired !== ef || full !== epf) begin
          bad++; $display("FAIL spawn_pulse got fired=%b full=%b exp fired=%b full=%b", fired, full, ef, epf);
        end
        for (int k = 0; k < N; k++) begin
          total++;
          if (valid[k] !== mv[k] || bx[k*XW +: XW] !== XW'(mx[k]) || by[k*YW +: YW] !== YW'(my[k])) begin
            bad++;
            $display("FAIL slot%0d got v=%b x=%0d y=%0d exp v=%b x=%0d y=%0d",
                     k, valid[k], bx[k*XW +: XW], by[k*YW +: YW], mv[k], mx[k], my[k]);
          end
        end
      end else begin
        total++;
        if (fired !== 1'b0 || full !== 1'b0) begin
          bad++; $display("FAIL stray_pulse cycle=%0d got fired=%b full=%b exp 0 0", c, fired, full);
        end
      end
    end
    cal = 0;
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL done_count got=%0d exp=1", dones);
    end
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if (valid !== '0 || bx !== '0 || by !== '0 || busy !== 0 || fired !== 0 || full !== 0 || done !== 0) begin
      bad++; $display("FAIL reset_state got v=%b busy=%b fired=%b full=%b done=%b exp all 0", valid, busy, fired, full, done);
    end
  endtask
  task automatic test_first_frame();
    run_frame(1, 1, 1, 0, 100, 400);
    fmask[0] = got_fired;
    total++;
    if (valid[0] !== 1'b1 || bx[9:0] !== 10'd100 || by[9:0] !== 10'd400) begin
      bad++; $display("FAIL first_spawn got v=%b x=%0d y=%0d exp 1 100 400", valid[0], bx[9:0], by[9:0]);
    end
  endtask
  task automatic test_cooldown();
    for (int f = 2; f <= 7; f++) begin
      run_frame(1, 1, 1, 0, 100, 400);
      fmask[f-1] = got_fired;
      if (f == 2) begin
        total++;
        if (by[9:0] !== 10'd396) begin bad++; $display("FAIL y_frame2 got=%0d exp=396", by[9:0]); end
      end
      if (f == 4) begin
        total++;
        if (by[9:0] !== 10'd388 || valid[1] !== 1'b1) begin
          bad++; $display("FAIL frame4 got y0=%0d v1=%b exp 388 1", by[9:0], valid[1]);
        end
      end
    end
    total++;
    if (fmask !== 7'b1001001) begin bad++; $display("FAIL fire_frames got=%b exp=1001001", fmask); end
  endtask
  task automatic test_retire();
    do_reset();
    run_frame(1, 1, 1, 0, 50, 6);
    run_frame(0, 0, 0, 0, 0, 0);
    total++;
    if (valid[0] !== 1'b1 || by[9:0] !== 10'd2) begin
      bad++; $display("FAIL boundary_move got v=%b y=%0d exp 1 2", valid[0], by[9:0]);
    end
    run_frame(0, 0, 0, 0, 0, 0);
    total++;
    if (valid[0] !== 1'b0 || by[9:0] !== 10'd2 || bx[9:0] !== 10'd50) begin
      bad++; $display("FAIL retire got v=%b x=%0d y=%0d exp 0 50 2", valid[0], bx[9:0], by[9:0]);
    end
  endtask
  task automatic test_pool_full();
    do_reset();
    for (int f = 1; f <= 14; f++) begin
      run_frame(1, 1, 1, 0, XW'(f), f == 7 ? YW'(26) : YW'(500));
      if (f == 13) begin
        total++;
        if (got_full !== 1'b1 || got_fired !== 1'b0) begin
          bad++; $display("FAIL pool_full got full=%b fired=%b exp 1 0", got_full, got_fired);
        end
      end
      if (f == 14) begin
        total++;
        if (got_fired !== 1'b1 || valid[2] !== 1'b1 || bx[29:20] !== 10'd14) begin
          bad++; $display("FAIL slot_reuse got fired=%b v2=%b x2=%0d exp 1 1 14", got_fired, valid[2], bx[29:20]);
        end
      end
    end
  endtask
  task automatic test_ignore_cal();
    run_frame(1, 1, 1, 1, 7, 300);
    run_frame(0, 1, 0, 1, 8, 301);
  endtask
  task automatic test_shoot_timing();
    do_reset();
    run_frame(0, 0, 1, 0, 33, 200);
    total++;
    if (got_fired !== 1'b0) begin bad++; $display("FAIL late_shoot got fired=%b exp 0", got_fired); end
    run_frame(0, 1, 0, 0, 34, 201);
    total++;
    if (got_fired !== 1'b1) begin bad++; $display("FAIL cycle1_shoot got fired=%b exp 1", got_fired); end
  endtask
  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      bit a = 1'($urandom), b = 1'($urandom), c = 1'($urandom), e = 1'($urandom);
      run_frame(a, b, c, e, XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)));
    end
  endtask
  task automatic test_reset_mid();
    @(posedge clk); #1; cal = 1; shoot = 1;
    @(posedge clk); #1; cal = 0;
    @(posedge clk); #1; rst = 1;
    #1;
    total++;
    if (valid !== '0 || bx !== '0 || by !== '0 || busy !== 0 || fired !== 0 || full !== 0 || done !== 0) begin
      bad++; $display("FAIL mid_reset got v=%b busy=%b done=%b exp all 0", valid, busy, done);
    end
    @(posedge clk); #1; rst = 0; shoot = 0;
    model_reset();
    run_frame(1, 1, 1, 0, 77, 600);
    total++;
    if (got_fired !== 1'b1) begin bad++; $display("FAIL after_reset got fired=%b exp 1", got_fired); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_first_frame();
    test_cooldown();
    test_retire();
    test_pool_full();
    test_ignore_cal();
    test_shoot_timing();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
